// File: rtl/spi_slave_responder.sv
// -----------------------------------------------------------------------------
// spi_slave_responder
//
// Byte-oriented SPI slave for mode 0 (CPOL=0, CPHA=0). The block oversamples
// sclk, ss and mosi on the system clock. It deserialises MOSI into words and
// serialises caller-supplied words onto MISO, MSB first.
//
// Ports
//   clk       in   system clock, at least 8x the sclk frequency
//   rst       in   asynchronous reset, active-low
//   sclk      in   SPI clock from the master (asynchronous to clk)
//   ss        in   slave select, active-low (asynchronous)
//   mosi      in   master-out data (asynchronous)
//   miso      out  slave-out data
//   miso_oe   out  1 = drive the miso pad, 0 = release it
//   tx_data   in   next word to transmit; captured in the cycle tx_ack is set
//   tx_ack    out  1-cycle pulse: tx_data was captured, present the next word
//   rx_data   out  last complete received word; held until the next word
//   rx_valid  out  1-cycle pulse: rx_data was updated
//   byte_cnt  out  words completed in the current or last frame (saturating)
//   busy      out  1 while a frame is active
//   frame_err out  1-cycle pulse: ss rose while a partial word was pending
// -----------------------------------------------------------------------------
module spi_slave_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ack,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic [CNT_WIDTH-1:0]  byte_cnt,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // The sclk and ss chains carry one extra flop beyond the synchroniser so that
  // edges are found from the last two synchronised samples.
  logic [SYNC_STAGES:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES:0]   ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_tx_q, shift_tx_d;
  logic [DATA_WIDTH-1:0]  shift_rx_q, shift_rx_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
  logic                   reload_pend_q, reload_pend_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   tx_ack_q, tx_ack_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;

  logic                   sclk_rise_s, sclk_fall_s;
  logic                   ss_rise_s, ss_fall_s;
  logic                   mosi_s;
  logic [DATA_WIDTH-1:0]  rx_word_s;

  // Synchroniser chains shift the raw pins in at the LSB end.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-1:0], ss};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  // Edge detection on the newest synchronised sample against the one before it.
  always_comb begin
    sclk_rise_s = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
    sclk_fall_s = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
    ss_rise_s   = ss_sync_q[SYNC_STAGES-1] & ~ss_sync_q[SYNC_STAGES];
    ss_fall_s   = ~ss_sync_q[SYNC_STAGES-1] & ss_sync_q[SYNC_STAGES];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  end

  // Next-state and output logic. ss edges take priority over sclk edges.
  always_comb begin
    state_d       = state_q;
    shift_tx_d    = shift_tx_q;
    shift_rx_d    = shift_rx_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    reload_pend_d = reload_pend_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    tx_ack_d      = 1'b0;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;
    rx_word_s     = {shift_rx_q[DATA_WIDTH-2:0], mosi_s};

    case (state_q)
      IDLE: begin
        if (ss_fall_s) begin
          // Frame start: first word is presented before the first sclk rise.
          state_d       = SHIFT;
          shift_tx_d    = tx_data;
          tx_ack_d      = 1'b1;
          miso_d        = tx_data[DATA_WIDTH-1];
          miso_oe_d     = 1'b1;
          shift_rx_d    = {DATA_WIDTH{1'b0}};
          bit_cnt_d     = {BW{1'b0}};
          byte_cnt_d    = {CNT_WIDTH{1'b0}};
          reload_pend_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        if (ss_rise_s) begin
          state_d       = IDLE;
          miso_oe_d     = 1'b0;
          miso_d        = 1'b0;
          reload_pend_d = 1'b0;
          bit_cnt_d     = {BW{1'b0}};
          if (bit_cnt_q != {BW{1'b0}}) begin
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b0;
          end
        end else if (sclk_rise_s) begin
          shift_rx_d = rx_word_s;
          if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
            rx_data_d     = rx_word_s;
            rx_valid_d    = 1'b1;
            bit_cnt_d     = {BW{1'b0}};
            reload_pend_d = 1'b1;
            if (byte_cnt_q != {CNT_WIDTH{1'b1}}) begin
              byte_cnt_d = byte_cnt_q + CNT_WIDTH'(1);
            end else begin
              byte_cnt_d = byte_cnt_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else if (sclk_fall_s) begin
          if (reload_pend_q) begin
            // Word boundary: fetch the next word (also prefetches after the last).
            shift_tx_d    = tx_data;
            tx_ack_d      = 1'b1;
            miso_d        = tx_data[DATA_WIDTH-1];
            reload_pend_d = 1'b0;
          end else begin
            shift_tx_d = {shift_tx_q[DATA_WIDTH-2:0], 1'b0};
            miso_d     = shift_tx_q[DATA_WIDTH-2];
          end
        end else begin
          state_d = SHIFT;
        end
      end

      default: begin
        state_d   = IDLE;
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
      end
    endcase
  end

  // State and output registers; the ss chain resets low so a frame already in
  // progress at reset release is not joined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q   <= '0;
      ss_sync_q     <= '0;
      mosi_sync_q   <= '0;
      state_q       <= IDLE;
      shift_tx_q    <= '0;
      shift_rx_q    <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      reload_pend_q <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      tx_ack_q      <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      shift_tx_q    <= shift_tx_d;
      shift_rx_q    <= shift_rx_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      reload_pend_q <= reload_pend_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      tx_ack_q      <= tx_ack_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign tx_ack    = tx_ack_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign byte_cnt  = byte_cnt_q;
  assign busy      = (state_q == SHIFT);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_responder
//
// Self-checking bench for spi_slave_responder. A behavioural SPI master drives
// sclk at clk/16. Expectations come from the words the bench chose to send and
// to supply on tx_data. A second instance with CNT_WIDTH=2 checks saturation.
// -----------------------------------------------------------------------------
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       ss;
  logic       mosi;
  logic [7:0] tx_data;

  logic       miso, miso_oe, tx_ack, rx_valid, busy, frame_err;
  logic [7:0] rx_data;
  logic [3:0] byte_cnt;

  logic       miso2, miso_oe2, tx_ack2, rx_valid2, busy2, frame_err2;
  logic [7:0] rx_data2;
  logic [1:0] byte_cnt2;

  spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .byte_cnt(byte_cnt),
    .busy(busy), .frame_err(frame_err)
  );

  spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso2), .miso_oe(miso_oe2), .tx_data(tx_data), .tx_ack(tx_ack2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .byte_cnt(byte_cnt2),
    .busy(busy2), .frame_err(frame_err2)
  );

  always #5 clk = ~clk;

  int         tests_run    = 0;
  int         tests_failed = 0;

  logic [7:0] mosi_words [16];
  logic [7:0] tx_words   [16];
  logic       miso_cap   [128];

  int         tx_idx;
  int         tx_ack_cnt;
  int         frame_err_cnt;
  logic [7:0] rx_got   [$];
  logic [1:0] cnt2_got [$];

  // Monitor: samples outputs 1 time unit after each rising edge and feeds tx_data.
  initial begin
    tx_idx        = 0;
    tx_ack_cnt    = 0;
    frame_err_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_ack) begin
        tx_ack_cnt++;
        if (tx_idx < 15) tx_idx++;
        tx_data = tx_words[tx_idx];
      end
      if (rx_valid)  rx_got.push_back(rx_data);
      if (frame_err) frame_err_cnt++;
      if (rx_valid2) cnt2_got.push_back(byte_cnt2);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_begin();
    tx_ack_cnt    = 0;
    frame_err_cnt = 0;
    rx_got.delete();
    cnt2_got.delete();
    tx_idx  = 0;
    tx_data = tx_words[0];
    ss      = 1'b0;
    wait_clks(8);
  endtask

  // Mode 0 master: data changes while sclk is low, both sides sample on the rise.
  task automatic send_bits(input int first, input int nbits);
    for (int b = first; b < first + nbits; b++) begin
      logic [7:0] w;
      w    = mosi_words[b / 8];
      mosi = w[7 - (b % 8)];
      wait_clks(8);
      sclk        = 1'b1;
      miso_cap[b] = miso;
      wait_clks(8);
      sclk = 1'b0;
    end
  endtask

  task automatic frame_end();
    wait_clks(8);
    ss = 1'b1;
    wait_clks(16);
  endtask

  task automatic test_reset();
    rst = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_words[0] = 8'h00;
    tx_data = 8'h00;
    #1;
    tests_run++;
    if ({miso, miso_oe, tx_ack, rx_valid, busy, frame_err} !== 6'b000000 ||
        rx_data !== 8'h00 || byte_cnt !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_state: miso=%b oe=%b ack=%b rxv=%b busy=%b ferr=%b rx=%h cnt=%0d, all must be 0",
               miso, miso_oe, tx_ack, rx_valid, busy, frame_err, rx_data, byte_cnt);
    end
    wait_clks(4);
    rst = 1'b1;
    wait_clks(16);
    tests_run++;
    if (busy !== 1'b0 || tx_ack_cnt !== 0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b acks=%0d, required 0 and 0", busy, tx_ack_cnt);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] cap;
    tx_words[0] = 8'hA5; tx_words[1] = 8'h5A;
    mosi_words[0] = 8'h0B;
    frame_begin();
    tests_run++;
    if (busy !== 1'b1 || miso_oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_start: busy=%b oe=%b, required 1 and 1", busy, miso_oe);
    end
    send_bits(0, 8);
    frame_end();
    cap = 8'h00;
    for (int i = 0; i < 8; i++) cap = {cap[6:0], miso_cap[i]};
    tests_run++;
    if (cap !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_miso: got %h, required a5", cap);
    end
    tests_run++;
    if (rx_got.size() != 1 || rx_data !== 8'h0B) begin
      tests_failed++;
      $display("FAIL single_rx: %0d pulses rx=%h, required 1 pulse rx=0b", rx_got.size(), rx_data);
    end
    tests_run++;
    if (byte_cnt !== 4'd1 || tx_ack_cnt !== 2) begin
      tests_failed++;
      $display("FAIL single_counts: cnt=%0d acks=%0d, required 1 and 2", byte_cnt, tx_ack_cnt);
    end
    tests_run++;
    if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0 || frame_err_cnt !== 0) begin
      tests_failed++;
      $display("FAIL single_end: busy=%b oe=%b miso=%b ferr=%0d, required all 0",
               busy, miso_oe, miso, frame_err_cnt);
    end
  endtask

  task automatic test_burst();
    logic [7:0] exp_rx [3];
    logic [7:0] exp_tx [3];
    logic [7:0] cap;
    exp_rx = '{8'h0A, 8'h1F, 8'h00};
    exp_tx = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 3; k++) begin
      mosi_words[k] = exp_rx[k];
      tx_words[k]   = exp_tx[k];
    end
    tx_words[3] = 8'hEE;
    frame_begin();
    send_bits(0, 24);
    frame_end();
    tests_run++;
    if (rx_got.size() != 3) begin
      tests_failed++;
      $display("FAIL burst_rx_count: got %0d, required 3", rx_got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (rx_got[k] !== exp_rx[k]) begin
          tests_failed++;
          $display("FAIL burst_rx%0d: got %h, required %h", k, rx_got[k], exp_rx[k]);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      cap = 8'h00;
      for (int i = 0; i < 8; i++) cap = {cap[6:0], miso_cap[k*8 + i]};
      tests_run++;
      if (cap !== exp_tx[k]) begin
        tests_failed++;
        $display("FAIL burst_miso%0d: got %h, required %h", k, cap, exp_tx[k]);
      end
    end
    tests_run++;
    if (tx_ack_cnt !== 4 || byte_cnt !== 4'd3) begin
      tests_failed++;
      $display("FAIL burst_counts: acks=%0d cnt=%0d, required 4 and 3", tx_ack_cnt, byte_cnt);
    end
  endtask

  task automatic test_frame_err();
    mosi_words[0] = 8'($urandom);
    tx_words[0]   = 8'($urandom);
    frame_begin();
    send_bits(0, 5);
    frame_end();
    tests_run++;
    if (frame_err_cnt !== 1 || rx_got.size() != 0) begin
      tests_failed++;
      $display("FAIL frame_err: pulses=%0d rx=%0d, required 1 and 0", frame_err_cnt, rx_got.size());
    end
    tests_run++;
    if (busy !== 1'b0 || miso_oe !== 1'b0 || byte_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL frame_err_idle: busy=%b oe=%b cnt=%0d, required 0 0 0", busy, miso_oe, byte_cnt);
    end
  endtask

  task automatic test_async_reset();
    mosi_words[0] = 8'h96; mosi_words[1] = 8'h5C;
    tx_words[0] = 8'hFF; tx_words[1] = 8'hFF; tx_words[2] = 8'hFF;
    frame_begin();
    send_bits(0, 11);
    rst = 1'b0;
    #1;
    tests_run++;
    if ({miso, miso_oe, rx_valid, busy} !== 4'b0000 || byte_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset: miso=%b oe=%b rxv=%b busy=%b cnt=%0d, required all 0",
               miso, miso_oe, rx_valid, busy, byte_cnt);
    end
    wait_clks(3);
    ss = 1'b1;
    wait_clks(3);
    rst = 1'b1;
    wait_clks(16);
  endtask

  task automatic test_reset_rejoin();
    mosi_words[0] = 8'hC3;
    tx_words[0]   = 8'h81;
    frame_begin();
    send_bits(0, 3);
    rst = 1'b0;
    wait_clks(2);
    rst = 1'b1;
    rx_got.delete();
    send_bits(3, 5);
    wait_clks(8);
    tests_run++;
    if (rx_got.size() != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_join: rx=%0d busy=%b, required 0 and 0", rx_got.size(), busy);
    end
    ss = 1'b1;
    wait_clks(16);
    mosi_words[0] = 8'h3C;
    frame_begin();
    send_bits(0, 8);
    frame_end();
    tests_run++;
    if (rx_got.size() != 1 || rx_data !== 8'h3C) begin
      tests_failed++;
      $display("FAIL reset_rejoin: %0d pulses rx=%h, required 1 pulse rx=3c", rx_got.size(), rx_data);
    end
  endtask

  task automatic test_cnt_saturate();
    for (int k = 0; k < 6; k++) begin
      mosi_words[k] = 8'($urandom);
      tx_words[k]   = 8'($urandom);
    end
    frame_begin();
    send_bits(0, 40);
    frame_end();
    tests_run++;
    if (cnt2_got.size() != 5) begin
      tests_failed++;
      $display("FAIL sat_pulses: got %0d rx_valid, required 5", cnt2_got.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        int exp_c;
        exp_c = (k + 1 > 3) ? 3 : k + 1;
        tests_run++;
        if (int'(cnt2_got[k]) != exp_c) begin
          tests_failed++;
          $display("FAIL sat_cnt%0d: got %0d, required %0d", k, cnt2_got[k], exp_c);
        end
      end
    end
    tests_run++;
    if (byte_cnt2 !== 2'd3 || byte_cnt !== 4'd5) begin
      tests_failed++;
      $display("FAIL sat_final: cnt2=%0d cnt=%0d, required 3 and 5", byte_cnt2, byte_cnt);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n, p, bad;
      n = $urandom_range(1, 4);
      p = (it % 2 == 1) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 6; k++) begin
        mosi_words[k] = 8'($urandom);
        tx_words[k]   = 8'($urandom);
      end
      frame_begin();
      send_bits(0, n*8 + p);
      frame_end();
      tests_run++;
      if (rx_got.size() != n) begin
        tests_failed++;
        $display("FAIL rand%0d_rx_count: got %0d, required %0d", it, rx_got.size(), n);
      end else begin
        bad = 0;
        for (int k = 0; k < n; k++) if (rx_got[k] !== mosi_words[k]) bad++;
        tests_run++;
        if (bad != 0) begin
          tests_failed++;
          $display("FAIL rand%0d_rx_data: %0d wrong words, required 0", it, bad);
        end
      end
      bad = 0;
      for (int b = 0; b < n*8 + p; b++) begin
        logic [7:0] w;
        w = tx_words[b / 8];
        if (miso_cap[b] !== w[7 - (b % 8)]) bad++;
      end
      tests_run++;
      if (bad != 0) begin
        tests_failed++;
        $display("FAIL rand%0d_miso: %0d wrong bits, required 0", it, bad);
      end
      tests_run++;
      if (tx_ack_cnt != n + 1 || int'(byte_cnt) != n || frame_err_cnt != ((p != 0) ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL rand%0d_counts: acks=%0d cnt=%0d ferr=%0d, required %0d %0d %0d",
                 it, tx_ack_cnt, byte_cnt, frame_err_cnt, n + 1, n, (p != 0) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_burst();
    test_frame_err();
    test_async_reset();
    test_reset_rejoin();
    test_cnt_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
